// File: rtl/stream_mux.sv
// rtl/stream_mux.sv - N-to-1 handshaked stream mux with packet lock and registered output
module stream_mux #(
    parameter int DATA_WIDTH = 64,
    parameter int NUM_CH     = 5,
    parameter int SEL_WIDTH  = $clog2(NUM_CH)
) (
    input  logic                         i_clk,
    input  logic                         i_arstn,
    input  logic                         i_mode,
    input  logic [SEL_WIDTH-1:0]         i_sel,
    input  logic [NUM_CH-1:0]            i_valid,
    input  logic [NUM_CH*DATA_WIDTH-1:0] i_data,
    input  logic [NUM_CH-1:0]            i_last,
    output logic [NUM_CH-1:0]            o_ready,
    output logic                         o_valid,
    output logic [DATA_WIDTH-1:0]        o_data,
    output logic                         o_last,
    output logic [SEL_WIDTH-1:0]         o_ch,
    input  logic                         i_ready,
    output logic                         o_locked
);

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } state_t;

    localparam logic [SEL_WIDTH:0] NUM_CH_W = (SEL_WIDTH+1)'(NUM_CH);

    state_t                 state;
    state_t                 state_next;
    logic [SEL_WIDTH-1:0]   lock_ch;
    logic [SEL_WIDTH-1:0]   rr_ptr;
    logic [SEL_WIDTH-1:0]   grant;
    logic                   grant_valid;
    logic                   load_en;
    logic                   xfer_in;
    logic                   in_last;
    logic [DATA_WIDTH-1:0]  in_data;
    logic [SEL_WIDTH:0]     rr_idx;

    assign load_en  = !o_valid || i_ready;
    assign o_locked = (state == LOCKED);

    // Round-robin search runs backwards so the last hit is the first channel at or after rr_ptr.
    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        rr_idx      = '0;
        if (state == LOCKED) begin
            grant       = lock_ch;
            grant_valid = 1'b1;
        end else if (!i_mode) begin
            grant       = i_sel;
            grant_valid = ({1'b0, i_sel} < NUM_CH_W);
        end else begin
            for (int i = NUM_CH - 1; i >= 0; i--) begin
                rr_idx = {1'b0, rr_ptr} + (SEL_WIDTH+1)'(i);
                if (rr_idx >= NUM_CH_W) begin
                    rr_idx = rr_idx - NUM_CH_W;
                end
                if (i_valid[rr_idx[SEL_WIDTH-1:0]]) begin
                    grant       = rr_idx[SEL_WIDTH-1:0];
                    grant_valid = 1'b1;
                end
            end
        end
    end

    always_comb begin
        o_ready = '0;
        in_data = '0;
        in_last = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (grant == SEL_WIDTH'(k)) begin
                o_ready[k] = i_arstn && load_en && grant_valid && i_valid[k];
                in_data    = i_data[k*DATA_WIDTH +: DATA_WIDTH];
                in_last    = i_last[k];
            end
        end
    end

    assign xfer_in = |o_ready;

    always_comb begin
        state_next = state;
        if (xfer_in) begin
            state_next = in_last ? UNLOCKED : LOCKED;
        end
    end

    always_ff @(posedge i_clk or negedge i_arstn) begin
        if (!i_arstn) begin
            state <= UNLOCKED;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge i_clk or negedge i_arstn) begin
        if (!i_arstn) begin
            lock_ch <= '0;
            rr_ptr  <= '0;
            o_valid <= 1'b0;
            o_data  <= '0;
            o_last  <= 1'b0;
            o_ch    <= '0;
        end else begin
            if (xfer_in) begin
                if (!in_last) begin
                    lock_ch <= grant;
                end else begin
                    rr_ptr <= (grant == SEL_WIDTH'(NUM_CH - 1)) ? '0 : grant + 1'b1;
                end
            end
            if (load_en) begin
                o_valid <= xfer_in;
                if (xfer_in) begin
                    o_data <= in_data;
                    o_last <= in_last;
                    o_ch   <= grant;
                end
            end
        end
    end

endmodule
